// File: rtl/sb_tx_arbiter_pkg.sv
// Shared sideband definitions: message width, arbiter FSM states and the
// default post-transfer idle gap.
package sb_pkg;

  localparam int SB_MSG_W      = 64;
  localparam int SB_GAP_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } sb_arb_state_e;

endpackage

// File: rtl/sb_tx_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request after ptr,
// searching upwards modulo NUM_REQ. Shared with the RX dispatcher.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any_req
);

  always_comb begin : pick
    int          cand;
    logic        found;
    logic [IW-1:0] cidx;
    grant   = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    // ptr itself is visited last, so the previous owner has lowest priority
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Shares the sideband TX serializer between NUM_REQ message sources: one
// message in flight, round-robin grant, done timeout and post-transfer gap.
module sb_tx_arbiter
  import sb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = SB_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk_100MHz,
  input  logic                        reset,
  input  logic                        enable_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*SB_MSG_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [SB_MSG_W-1:0]         tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  input  logic                        tx_done_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        timeout_err_o,
  output sb_arb_state_e               dbg_state_o
);

  // Handshakes: requester k transfers when req_valid_i[k] & req_ready_o[k]
  // (ready only in IDLE, never during reset); the serializer takes tx_data_o
  // when tx_valid_o & tx_ready_i. Valid may not depend on ready on either side.

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  // Timeout fires on the cycle whose increment would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TO_LAST  = (TIMEOUT_CYCLES >= 2) ? TW'(TIMEOUT_CYCLES - 2) : '0;
  localparam sb_arb_state_e AFTER_TX = (GAP_CYCLES > 0) ? GAP : IDLE;

  sb_arb_state_e      state;
  logic [IW-1:0]      rr_ptr;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      to_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               grant_now;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign grant_now   = (state == IDLE) && enable_i && arb_any && !reset;
  assign req_ready_o = grant_now ? arb_grant : '0;
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= IW'(NUM_REQ - 1);
      tx_data_o     <= '0;
      tx_valid_o    <= 1'b0;
      grant_o       <= '0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) begin
            tx_data_o  <= req_data_i[arb_idx*SB_MSG_W +: SB_MSG_W];
            grant_o    <= arb_grant;
            rr_ptr     <= arb_idx;
            tx_valid_o <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            to_cnt     <= '0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done_i || to_cnt == TO_LAST) begin
            if (!tx_done_i) timeout_err_o <= 1'b1;
            gap_cnt <= '0;
            state   <= AFTER_TX;
            if (GAP_CYCLES == 0) grant_o <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            grant_o <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter: interval-based reference model of grant timing,
// scoreboard of granted messages, directed cases then randomized traffic.
module tb_sb_tx_arbiter;
  import sb_pkg::*;

  localparam int NR  = 4;
  localparam int G   = 4;
  localparam int T   = 64;
  localparam int W   = 64;
  localparam int BIG = 1 << 30;

  // ---------------- clock / reset / DUT ----------------
  logic                clk_100MHz = 1'b0;
  logic                reset;
  logic                enable_i;
  logic [NR-1:0]       req_valid_i;
  logic [NR*W-1:0]     req_data_i;
  logic [NR-1:0]       req_ready_o;
  logic [W-1:0]        tx_data_o;
  logic                tx_valid_o;
  logic                tx_ready_i;
  logic                tx_done_i;
  logic [NR-1:0]       grant_o;
  logic                busy_o;
  logic                timeout_err_o;
  sb_arb_state_e       dbg_state_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  sb_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .enable_i      (enable_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .tx_done_i     (tx_done_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o),
    .timeout_err_o (timeout_err_o),
    .dbg_state_o   (dbg_state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- requester drivers ----------------
  int          issued[NR];
  int          sent[NR];
  bit          use_seed = 1'b0;
  bit          drop_en  = 1'b0;
  logic [63:0] seed_data[NR];

  initial begin : requesters
    logic [NR-1:0] hs;
    bit            dropped;
    req_valid_i = '0;
    req_data_i  = '0;
    for (int k = 0; k < NR; k++) sent[k] = 0;
    forever begin
      @(negedge clk_100MHz);
      hs = req_ready_o & req_valid_i;
      @(posedge clk_100MHz); #1;
      for (int k = 0; k < NR; k++) begin
        dropped = 1'b0;
        if (hs[k]) sent[k]++;
        else if (req_valid_i[k] && drop_en && $urandom_range(0, 15) == 0) begin
          req_valid_i[k] = 1'b0;
          dropped        = 1'b1;
        end
        if (!dropped && sent[k] < issued[k] && (hs[k] || !req_valid_i[k])) begin
          req_valid_i[k]     = 1'b1;
          req_data_i[k*W+:W] = use_seed ? seed_data[k] : {$urandom, $urandom};
        end else if (sent[k] >= issued[k]) begin
          req_valid_i[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- serializer driver ----------------
  int ser_ready_lat = 0;
  int ser_done_lat  = 1;
  bit ser_no_done   = 1'b0;
  bit ser_rand      = 1'b0;

  initial begin : serializer
    int rl, dl;
    bit nd;
    tx_ready_i = 1'b0;
    tx_done_i  = 1'b0;
    forever begin
      @(posedge clk_100MHz); #1;
      if (tx_valid_o && !reset) begin
        rl = ser_rand ? int'($urandom_range(0, 3)) : ser_ready_lat;
        dl = ser_rand ? int'($urandom_range(1, 8)) : ser_done_lat;
        nd = ser_rand ? ($urandom_range(0, 19) == 0) : ser_no_done;
        repeat (rl) begin @(posedge clk_100MHz); #1; end
        tx_ready_i = 1'b1;
        @(posedge clk_100MHz); #1;
        tx_ready_i = 1'b0;
        if (!nd) begin
          repeat (dl - 1) begin @(posedge clk_100MHz); #1; end
          tx_done_i = 1'b1;
          @(posedge clk_100MHz); #1;
          tx_done_i = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  logic [W-1:0]  exp_q[$];
  logic [NR-1:0] expg_q[$];
  int            rise_q[$];
  int            dut_win_q[$];

  initial begin : monitor
    int            ptr, acc_cyc, rdy_cyc, free_at, err_from, win, c, k;
    bit            in_flight, prev_v, rst_prev, busy_exp, issue_exp;
    logic [NR-1:0] cur_grant, exp_rdy, oh, g;
    logic [W-1:0]  cur_data;
    ptr = NR - 1; acc_cyc = -100; rdy_cyc = -200; free_at = 0; err_from = BIG;
    in_flight = 1'b0; prev_v = 1'b0; rst_prev = 1'b1;
    cur_grant = '0; cur_data = '0;
    forever begin
      @(negedge clk_100MHz);
      c = cyc;
      if (rst_prev) begin
        check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
        check("rst_tx_data", tx_data_o, 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_timeout_err", 64'(timeout_err_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(IDLE));
        ptr = NR - 1; acc_cyc = -100; rdy_cyc = -200; free_at = 0; err_from = BIG;
        in_flight = 1'b0; cur_grant = '0;
        exp_q.delete(); expg_q.delete();
      end
      if (reset) begin
        check("ready_in_reset", 64'(req_ready_o), 64'd0);
      end else begin
        busy_exp  = (c > acc_cyc) && (c < free_at);
        issue_exp = busy_exp && (rdy_cyc < acc_cyc);
        exp_rdy   = '0;
        win       = -1;
        if (!busy_exp && enable_i && |req_valid_i) begin
          for (int i = 1; i <= NR; i++) begin
            k = (ptr + i) % NR;
            if (win < 0 && req_valid_i[k]) win = k;
          end
          exp_rdy[win] = 1'b1;
        end
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        check("busy", 64'(busy_o), 64'(busy_exp));
        check("grant", 64'(grant_o), 64'(busy_exp ? cur_grant : '0));
        check("tx_valid", 64'(tx_valid_o), 64'(issue_exp));
        check("timeout_err", 64'(timeout_err_o), 64'(c >= err_from));
        if (tx_valid_o && !prev_v) begin
          rise_q.push_back(c);
          k = -1;
          for (int i = 0; i < NR; i++) if (grant_o[i]) k = i;
          dut_win_q.push_back(k);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow cyc=%0d got=tx_valid exp=no_message", c);
          end else begin
            cur_data = exp_q.pop_front();
            g        = expg_q.pop_front();
            check("sb_grant", 64'(grant_o), 64'(g));
          end
        end
        if (tx_valid_o) check("tx_data", tx_data_o, cur_data);
        if (win >= 0) begin
          oh = '0; oh[win] = 1'b1;
          exp_q.push_back(req_data_i[win*W+:W]);
          expg_q.push_back(oh);
          ptr = win; acc_cyc = c; free_at = BIG; cur_grant = oh;
        end
        if (issue_exp && tx_ready_i) begin
          rdy_cyc = c; in_flight = 1'b1;
        end else if (in_flight && c > rdy_cyc) begin
          if (tx_done_i) begin
            free_at = c + 1 + G; in_flight = 1'b0;
          end else if (c == rdy_cyc + T - 1) begin
            if (err_from == BIG) err_from = c + 1;
            free_at = c + 1 + G; in_flight = 1'b0;
          end
        end
      end
      prev_v   = tx_valid_o;
      rst_prev = reset;
    end
  end

  // ---------------- main sequence ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk_100MHz); #1; end
  endtask

  function automatic bit all_sent();
    for (int k = 0; k < NR; k++) if (sent[k] != issued[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(input string name, input int budget);
    int q, n;
    q = 0; n = 0;
    while (q < 3 && n < budget) begin
      step(1); n++;
      if (all_sent() && !busy_o && !tx_valid_o) q++; else q = 0;
    end
    checks++;
    if (q < 3) begin
      failures++;
      $display("FAIL %s_timeout cyc=%0d got=still_busy exp=idle_within_%0d", name, cyc, budget);
    end
  endtask

  task automatic check_gaps(input string name, input int first, input int exp_gap);
    for (int i = first + 1; i < rise_q.size(); i++)
      check(name, 64'(rise_q[i] - rise_q[i-1]), 64'(exp_gap));
  endtask

  initial begin : main
    int n0, s2;
    int order[5];
    reset    = 1'b1;
    enable_i = 1'b0;
    for (int k = 0; k < NR; k++) begin issued[k] = 0; seed_data[k] = '0; end
    step(3);
    reset    = 1'b0;
    enable_i = 1'b1;
    step(2);

    // all four valid, immediate ready/done: order 0,1,2,3,0, 7-cycle spacing
    n0 = rise_q.size();
    issued[0] += 2; issued[1]++; issued[2]++; issued[3]++;
    wait_quiet("rr_fast", 400);
    check("rr_fast_count", 64'(rise_q.size() - n0), 64'd5);
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      if (n0 + i < dut_win_q.size()) check("rr_order", 64'(dut_win_q[n0+i]), 64'(order[i]));
    check_gaps("rr_fast_spacing", n0, 3 + G);

    // done 20 cycles after ready: 26-cycle spacing
    n0 = rise_q.size();
    ser_done_lat = 20;
    for (int k = 0; k < NR; k++) issued[k]++;
    wait_quiet("rr_slow", 600);
    check("rr_slow_count", 64'(rise_q.size() - n0), 64'd4);
    check_gaps("rr_slow_spacing", n0, 26);

    // single requester 2 with fixed payload
    n0 = rise_q.size();
    use_seed = 1'b1;
    seed_data[2] = 64'hDEAD_BEEF_0123_4567;
    issued[2]++;
    wait_quiet("single", 200);
    check("single_count", 64'(rise_q.size() - n0), 64'd1);
    if (n0 < dut_win_q.size()) check("single_owner", 64'(dut_win_q[n0]), 64'd2);
    use_seed = 1'b0;

    // serializer stalls ready for 10 cycles while others wait
    n0 = rise_q.size();
    ser_ready_lat = 10; ser_done_lat = 1;
    issued[1]++;
    step(2);
    issued[2]++; issued[3]++;
    wait_quiet("stall", 300);
    check("stall_count", 64'(rise_q.size() - n0), 64'd3);
    ser_ready_lat = 0;

    // done never arrives: timeout, then normal service with sticky error
    ser_no_done = 1'b1;
    issued[0]++;
    wait_quiet("timeout", 300);
    check("timeout_sticky", 64'(timeout_err_o), 64'd1);
    check("timeout_idle", 64'(dbg_state_o), 64'(IDLE));
    ser_no_done = 1'b0;
    n0 = rise_q.size();
    issued[1]++;
    wait_quiet("after_timeout", 200);
    check("after_timeout_count", 64'(rise_q.size() - n0), 64'd1);
    check("after_timeout_err", 64'(timeout_err_o), 64'd1);

    // enable low blocks grants; dropping it mid-transfer lets the transfer finish
    enable_i = 1'b0;
    s2 = sent[0];
    issued[0]++;
    step(10);
    check("disabled_no_accept", 64'(sent[0]), 64'(s2));
    enable_i = 1'b1;
    wait_quiet("enable_resume", 200);
    ser_done_lat = 20;
    issued[1]++; issued[2]++;
    step(6);
    enable_i = 1'b0;
    s2 = sent[2];
    step(40);
    check("mid_disable_idle", 64'(busy_o), 64'd0);
    check("mid_disable_no_grant", 64'(sent[2]), 64'(s2));
    enable_i = 1'b1;
    wait_quiet("mid_disable_resume", 200);
    check("mid_disable_served", 64'(sent[2]), 64'(s2 + 1));
    ser_done_lat = 1;

    // reset while waiting for done; afterwards requester 0 beats 3
    ser_no_done = 1'b1;
    issued[2]++;
    step(6);
    reset = 1'b1;
    issued[3]++; issued[0]++;
    step(1);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_state", 64'(dbg_state_o), 64'(IDLE));
    step(1);
    ser_no_done = 1'b0;
    n0 = dut_win_q.size();
    reset = 1'b0;
    wait_quiet("post_reset", 200);
    if (n0 + 1 < dut_win_q.size()) begin
      check("post_reset_first", 64'(dut_win_q[n0]), 64'd0);
      check("post_reset_second", 64'(dut_win_q[n0+1]), 64'd3);
    end else begin
      checks++; failures++;
      $display("FAIL post_reset_grants got=%0d exp=2", dut_win_q.size() - n0);
    end

    // randomized traffic, latencies, drops and enable toggling
    ser_rand = 1'b1;
    drop_en  = 1'b1;
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 7) == 0) issued[$urandom_range(0, NR-1)]++;
      if ($urandom_range(0, 19) == 0) enable_i = ~enable_i;
      step(1);
    end
    enable_i = 1'b1;
    drop_en  = 1'b0;
    wait_quiet("random", 5000);
    ser_rand = 1'b0;

    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_tx_arbiter.md
Name: sb_tx_arbiter

Overview:
- Shares the single 64-bit sideband serializer between NUM_REQ requesters, e.g. link-training FSM, register-access engine and error reporter.
- Round-robin grant, one 64-bit message in flight at a time.
- Enforces the 32-UI post-transfer idle gap the sideband receiver requires before the next message.
- Sits in the logphy between the message sources and the sideband TX serializer, in the clk_100MHz domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 4, clk_100MHz cycles of idle after serializer done (32 UI at 800MHz = 4); 0 allowed.
- TIMEOUT_CYCLES, 64, max cycles waiting for tx_done_i before abort.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  allows new grants.
- req_valid_i  in  NUM_REQ  per-requester message valid.
- req_data_i  in  NUM_REQ*64  packed messages; requester k at [64k+63:64k].
- req_ready_o  out  NUM_REQ  one-hot accept; handshake on valid&ready.
- tx_data_o  out  64  message to serializer.
- tx_valid_o  out  1  message offered to serializer.
- tx_ready_i  in  1  serializer accepts message.
- tx_done_i  in  1  one-cycle pulse, last bit shifted out.
- grant_o  out  NUM_REQ  one-hot owner of the in-flight message; 0 when idle.
- busy_o  out  1  state != IDLE.
- timeout_err_o  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first. All outputs 0, including tx_data_o and timeout_err_o. Reset mid-transfer drops the message with no completion.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If enable_i and |req_valid_i: the winner is the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in this cycle only.
  - At the clock edge: latch req_data_i[winner] into tx_data_o; grant_o=onehot(winner); rr_ptr=winner; go to ISSUE.
  - req_ready_o is 0 in every other state.
- ISSUE:
  - tx_valid_o=1; tx_data_o is held stable.
  - On tx_ready_i: tx_valid_o=0 next cycle; go to WAIT_DONE; clear the timeout counter.
  - Latency: accept at cycle N, tx_valid_o high at N+1.
- WAIT_DONE:
  - On tx_done_i: go to GAP, or to IDLE if GAP_CYCLES==0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without done: set timeout_err_o and go to GAP/IDLE as above.
- GAP:
  - The counter runs 0..GAP_CYCLES-1, then IDLE. No grant is issued during GAP.
  - Minimum spacing between two tx_valid_o rising edges = 3 + GAP_CYCLES cycles, given ready and done arrive immediately.
- grant_o is held from ISSUE through GAP and cleared on entry to IDLE.
- tx_done_i is ignored outside WAIT_DONE. Done in the same cycle as the accepting tx_ready_i is also ignored; the serializer never does this.
- enable_i low gates only new grants in IDLE. An in-flight message always completes.
- Requesters hold req_data_i stable while req_valid_i is high. A requester dropping valid before ready loses its turn; nothing is latched.
- Counter widths: $clog2(GAP_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1). No wrap beyond the terminal value.

Decomposition:
- Shared package sb_pkg holds:
  - SB_MSG_W = 64.
  - typedef enum sb_arb_state_e {IDLE, ISSUE, WAIT_DONE, GAP}.
  - Default SB_GAP_CYCLES = 4.
- Sub-module rr_arbiter (NUM_REQ): purely combinational. Inputs req vector and ptr; outputs onehot grant and index plus any_req. Reusable for the RX dispatcher.

Test Plan:
- Single requester: req_valid_i=4'b0100 with data 64'hDEAD_BEEF_0123_4567, tx_ready_i tied 1, done 20 cycles later.
  Expect req_ready_o=4'b0100 for 1 cycle, tx_valid_o for exactly 1 cycle with that data, grant_o=4'b0100, busy_o low 4 cycles after done.
- All four requesters valid continuously.
  Expect grant order 0,1,2,3,0. Expect tx_valid_o rising edges exactly 7 cycles apart with immediate ready/done, and 26 apart with done 20 cycles after ready.
- tx_ready_i held low for 10 cycles.
  Expect tx_valid_o and tx_data_o stable for all 10 cycles, and no other req_ready_o asserted.
- tx_done_i never arrives.
  Expect timeout_err_o=1 at cycle TIMEOUT_CYCLES after ready. Expect the FSM to pass GAP and return to IDLE. Expect the next request still to be served with timeout_err_o remaining 1.
- enable_i=0 with req_valid_i=4'b0001.
  Expect no ready. Drop enable_i mid-WAIT_DONE: the current message completes and there is no new grant until enable_i=1.
- reset asserted in WAIT_DONE.
  Expect all outputs 0 on the next cycle and state IDLE. After release with requesters 3 and 0 valid, requester 0 wins first.
